// File: rtl/ddr3_cmd_ctrl.sv
// ddr3_cmd_ctrl
//   Host-side DDR3 initiator. Turns single BL8 read/write requests into closed-page
//   ACT -> RD/WR -> PRE command sequences and inserts periodic auto-refresh.
//   Data path is an SDR abstraction: two beats per clk, four clks per BL8.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake (one outstanding request)
//   req_we                1 = write, 0 = read
//   req_addr              {ba, row, col}
//   req_wdata             BL8 write data, beat0 in LSBs
//   rd_valid/rd_data      one-cycle pulse with BL8 read data, beat0 in LSBs
//   ddr_rst_n             memory reset
//   ras_n/cas_n/we_n      command pins
//   ba, addr              bank and row/column address (A10=0 on RD/WR/PRE)
//   dq_out/dq_oe          write beats {odd,even} and drive enable
//   dq_in                 read beats {odd,even}
//   odt                   on-die termination
module ddr3_cmd_ctrl #(
    parameter int unsigned BA_W   = 3,
    parameter int unsigned ROW_W  = 14,
    parameter int unsigned COL_W  = 10,
    parameter int unsigned DQ_W   = 8,
    parameter int unsigned T_RST  = 200,
    parameter int unsigned T_RCD  = 5,
    parameter int unsigned T_RAS  = 15,
    parameter int unsigned T_RP   = 5,
    parameter int unsigned CL     = 5,
    parameter int unsigned CWL    = 5,
    parameter int unsigned T_WR   = 6,
    parameter int unsigned T_REFI = 780,
    parameter int unsigned T_RFC  = 44
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [BA_W+ROW_W+COL_W-1:0] req_addr,
    input  logic [8*DQ_W-1:0]           req_wdata,
    output logic                        rd_valid,
    output logic [8*DQ_W-1:0]           rd_data,
    output logic                        ddr_rst_n,
    output logic                        ras_n,
    output logic                        cas_n,
    output logic                        we_n,
    output logic [BA_W-1:0]             ba,
    output logic [ROW_W-1:0]            addr,
    output logic [2*DQ_W-1:0]           dq_out,
    output logic                        dq_oe,
    input  logic [2*DQ_W-1:0]           dq_in,
    output logic                        odt
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned REF_W = $clog2(T_REFI);

    // Sequence timing is expressed in "decision cycles": cnt value of the cycle whose
    // combinational result becomes visible on the pins one clk later. cnt is 0 in the
    // cycle after the accepting edge, so ACT is decided at 0 and visible at E+1.
    localparam int unsigned WR_PRE_I = T_RCD + CWL + 3 + T_WR + 1;
    localparam int unsigned RD_PRE_I = T_RCD + CL + 4;

    localparam logic [CNT_W-1:0] RST_END  = CNT_W'(T_RST);
    localparam logic [CNT_W-1:0] RCD_END  = CNT_W'(T_RCD);
    localparam logic [CNT_W-1:0] WR_BEAT0 = CNT_W'(T_RCD + CWL);
    localparam logic [CNT_W-1:0] WR_BEAT3 = CNT_W'(T_RCD + CWL + 3);
    localparam logic [CNT_W-1:0] RD_CAP0  = CNT_W'(T_RCD + CL + 1);
    localparam logic [CNT_W-1:0] RD_CAP3  = CNT_W'(T_RCD + CL + 4);
    localparam logic [CNT_W-1:0] WR_PRE   = CNT_W'((T_RAS > WR_PRE_I) ? T_RAS : WR_PRE_I);
    localparam logic [CNT_W-1:0] RD_PRE   = CNT_W'((T_RAS > RD_PRE_I) ? T_RAS : RD_PRE_I);
    localparam logic [CNT_W-1:0] RP_END   = CNT_W'(T_RP);
    localparam logic [CNT_W-1:0] RFC_END  = CNT_W'(T_RFC);
    localparam logic [REF_W-1:0] REFI_END = REF_W'(T_REFI - 1);

    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_REF = 3'b001;

    typedef enum logic [2:0] {
        StRstWait,
        StIdle,
        StAct,
        StTrcd,
        StData,
        StTrp,
        StTrfc
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [REF_W-1:0]       ref_cnt_q, ref_cnt_d;
    logic                   ref_pending_q, ref_pending_d;

    logic                   acc_we_q, acc_we_d;
    logic [BA_W-1:0]        acc_ba_q, acc_ba_d;
    logic [ROW_W-1:0]       acc_row_q, acc_row_d;
    logic [COL_W-1:0]       acc_col_q, acc_col_d;
    logic [8*DQ_W-1:0]      wdata_q, wdata_d;
    logic [8*DQ_W-1:0]      rd_buf_q, rd_buf_d;

    logic [2:0]             cmd_q, cmd_d;
    logic [BA_W-1:0]        ba_q, ba_d;
    logic [ROW_W-1:0]       addr_q, addr_d;
    logic [2*DQ_W-1:0]      dq_out_q, dq_out_d;
    logic                   dq_oe_q, dq_oe_d;
    logic                   odt_q, odt_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [8*DQ_W-1:0]      rd_data_q, rd_data_d;

    logic [CNT_W-1:0]       pre_at;

    assign pre_at = acc_we_q ? WR_PRE : RD_PRE;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CNT_W'(1);
        ref_cnt_d     = ref_cnt_q;
        ref_pending_d = ref_pending_q;
        acc_we_d      = acc_we_q;
        acc_ba_d      = acc_ba_q;
        acc_row_d     = acc_row_q;
        acc_col_d     = acc_col_q;
        wdata_d       = wdata_q;
        rd_buf_d      = rd_buf_q;
        cmd_d         = CMD_NOP;
        ba_d          = '0;
        addr_d        = '0;
        dq_out_d      = '0;
        dq_oe_d       = 1'b0;
        odt_d         = 1'b0;
        rd_valid_d    = 1'b0;
        rd_data_d     = rd_data_q;
        req_ready     = 1'b0;

        unique case (state_q)
            StRstWait: begin
                if (cnt_q == RST_END) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                req_ready = !ref_pending_q;
                if (ref_pending_q) begin
                    cmd_d         = CMD_REF;
                    ref_pending_d = 1'b0;
                    state_d       = StTrfc;
                    cnt_d         = '0;
                end else if (req_valid) begin
                    acc_we_d  = req_we;
                    acc_ba_d  = req_addr[ROW_W+COL_W +: BA_W];
                    acc_row_d = req_addr[COL_W +: ROW_W];
                    acc_col_d = req_addr[COL_W-1:0];
                    wdata_d   = req_wdata;
                    state_d   = StAct;
                    cnt_d     = '0;
                end
            end
            StAct: begin
                cmd_d   = CMD_ACT;
                ba_d    = acc_ba_q;
                addr_d  = acc_row_q;
                state_d = StTrcd;
            end
            StTrcd: begin
                if (cnt_q == RCD_END) begin
                    cmd_d   = acc_we_q ? CMD_WR : CMD_RD;
                    ba_d    = acc_ba_q;
                    addr_d  = {{(ROW_W-COL_W){1'b0}}, acc_col_q};
                    state_d = StData;
                end
            end
            StData: begin
                if (acc_we_q && cnt_q >= WR_BEAT0 && cnt_q <= WR_BEAT3) begin
                    // Write data drains from the low end, one beat pair per clk.
                    dq_out_d = wdata_q[2*DQ_W-1:0];
                    wdata_d  = {{(2*DQ_W){1'b0}}, wdata_q[8*DQ_W-1:2*DQ_W]};
                    dq_oe_d  = 1'b1;
                    odt_d    = 1'b1;
                end
                if (!acc_we_q && cnt_q >= RD_CAP0 && cnt_q <= RD_CAP3) begin
                    // Shift in from the top so beat0 lands in the LSBs after four captures.
                    rd_buf_d = {dq_in, rd_buf_q[8*DQ_W-1:2*DQ_W]};
                    if (cnt_q == RD_CAP3) begin
                        rd_data_d  = rd_buf_d;
                        rd_valid_d = 1'b1;
                    end
                end
                if (cnt_q == pre_at) begin
                    cmd_d   = CMD_PRE;
                    ba_d    = acc_ba_q;
                    state_d = StTrp;
                    cnt_d   = '0;
                end
            end
            StTrp: begin
                if (cnt_q == RP_END) begin
                    state_d = StIdle;
                end
            end
            StTrfc: begin
                if (cnt_q == RFC_END) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StRstWait;
            end
        endcase

        // Free-running refresh interval; a fresh expiry wins over a same-cycle clear.
        if (state_q != StRstWait) begin
            if (ref_cnt_q == REFI_END) begin
                ref_cnt_d     = '0;
                ref_pending_d = 1'b1;
            end else begin
                ref_cnt_d = ref_cnt_q + REF_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StRstWait;
            cnt_q         <= '0;
            ref_cnt_q     <= '0;
            ref_pending_q <= 1'b0;
            acc_we_q      <= 1'b0;
            acc_ba_q      <= '0;
            acc_row_q     <= '0;
            acc_col_q     <= '0;
            wdata_q       <= '0;
            rd_buf_q      <= '0;
            cmd_q         <= CMD_NOP;
            ba_q          <= '0;
            addr_q        <= '0;
            dq_out_q      <= '0;
            dq_oe_q       <= 1'b0;
            odt_q         <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ref_cnt_q     <= ref_cnt_d;
            ref_pending_q <= ref_pending_d;
            acc_we_q      <= acc_we_d;
            acc_ba_q      <= acc_ba_d;
            acc_row_q     <= acc_row_d;
            acc_col_q     <= acc_col_d;
            wdata_q       <= wdata_d;
            rd_buf_q      <= rd_buf_d;
            cmd_q         <= cmd_d;
            ba_q          <= ba_d;
            addr_q        <= addr_d;
            dq_out_q      <= dq_out_d;
            dq_oe_q       <= dq_oe_d;
            odt_q         <= odt_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign {ras_n, cas_n, we_n} = cmd_q;
    assign ba        = ba_q;
    assign addr      = addr_q;
    assign dq_out    = dq_out_q;
    assign dq_oe     = dq_oe_q;
    assign odt       = odt_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign ddr_rst_n = (state_q != StRstWait);

endmodule

// File: tb/tb_ddr3_cmd_ctrl.sv
// tb_ddr3_cmd_ctrl
//   Directed bench for ddr3_cmd_ctrl. Cycle n is the window that starts with the
//   n-th rising edge after reset release; every signal is logged #1 after that edge.
module tb_ddr3_cmd_ctrl;

    localparam int NL = 2100;

    localparam logic [2:0] NOP = 3'b111;
    localparam logic [2:0] ACT = 3'b011;
    localparam logic [2:0] RD  = 3'b101;
    localparam logic [2:0] WR  = 3'b100;
    localparam logic [2:0] PRE = 3'b010;
    localparam logic [2:0] REF = 3'b001;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [26:0] req_addr;
    logic [63:0] req_wdata;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic        ddr_rst_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic [2:0]  ba;
    logic [13:0] addr;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic [15:0] dq_in;
    logic        odt;

    ddr3_cmd_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .ddr_rst_n (ddr_rst_n),
        .ras_n     (ras_n),
        .cas_n     (cas_n),
        .we_n      (we_n),
        .ba        (ba),
        .addr      (addr),
        .dq_out    (dq_out),
        .dq_oe     (dq_oe),
        .dq_in     (dq_in),
        .odt       (odt)
    );

    always #5 clk = ~clk;

    int          cyc;
    int          n_vec;
    int          n_err;
    int          acc_cyc;
    int          rd_base;
    logic [63:0] rd_beats;

    logic [2:0]  l_cmd  [NL];
    logic [2:0]  l_ba   [NL];
    logic [13:0] l_addr [NL];
    logic [15:0] l_dq   [NL];
    logic        l_oe   [NL];
    logic        l_odt  [NL];
    logic        l_rdv  [NL];
    logic [63:0] l_rdd  [NL];
    logic        l_rdy  [NL];
    logic        l_rstn [NL];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic log_now();
        if (cyc >= 0 && cyc < NL) begin
            l_cmd[cyc]  = {ras_n, cas_n, we_n};
            l_ba[cyc]   = ba;
            l_addr[cyc] = addr;
            l_dq[cyc]   = dq_out;
            l_oe[cyc]   = dq_oe;
            l_odt[cyc]  = odt;
            l_rdv[cyc]  = rd_valid;
            l_rdd[cyc]  = rd_data;
            l_rdy[cyc]  = req_ready;
            l_rstn[cyc] = ddr_rst_n;
        end
    endtask

    // One clk: drop req_valid after a handshake, drive the read beats of the
    // current read (cycles base+11 .. base+14), then log.
    task automatic tick();
        logic acc;
        int   rel;
        acc = req_valid && req_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin
            req_valid = 1'b0;
            acc_cyc   = cyc;
        end
        rel = cyc - rd_base;
        if (rel >= 11 && rel <= 14) dq_in = rd_beats[16*(rel-11) +: 16];
        else dq_in = '0;
        log_now();
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic issue(input logic we, input logic [2:0] b, input logic [13:0] r,
                         input logic [9:0] c, input logic [63:0] wd);
        req_we    = we;
        req_addr  = {b, r, c};
        req_wdata = wd;
        req_valid = 1'b1;
    endtask

    // sel: 0 cmd==c, 1 dq_oe, 2 odt, 3 rd_valid, 4 req_ready, 5 ddr_rst_n
    function automatic int count(input int sel, input int lo, input int hi,
                                 input logic [2:0] c);
        int n;
        n = 0;
        for (int i = lo; i <= hi; i++) begin
            case (sel)
                0: if (l_cmd[i] === c) n++;
                1: if (l_oe[i] === 1'b1) n++;
                2: if (l_odt[i] === 1'b1) n++;
                3: if (l_rdv[i] === 1'b1) n++;
                4: if (l_rdy[i] === 1'b1) n++;
                default: if (l_rstn[i] === 1'b1) n++;
            endcase
        end
        return n;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        dq_in     = '0;
        rd_beats  = '0;
        rd_base   = -1000;
        cyc       = 0;
        acc_cyc   = -1;
        n_vec     = 0;
        n_err     = 0;

        // T1: reset pulse and init wait
        #3 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ddr_rst_n", ddr_rst_n, 0);
        check("rst_cmd", {ras_n, cas_n, we_n}, NOP);
        check("rst_req_ready", req_ready, 0);
        check("rst_oe_odt_rdv", {dq_oe, odt, rd_valid}, 0);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        log_now();
        wait_until(201);
        check("t1_rstn_low_0_200", count(5, 0, 200, NOP), 0);
        check("t1_nop_0_201", count(0, 0, 201, NOP), 202);
        check("t1_ready_200", l_rdy[200], 0);
        check("t1_rstn_201", l_rstn[201], 1);
        check("t1_ready_201", l_rdy[201], 1);

        // T2: write, closed page, T_WR-bound precharge
        issue(1'b1, 3'd2, 14'h1234, 10'h010, 64'h0807060504030201);
        wait_until(232);
        e = 202;
        check("t2_accept", acc_cyc, e);
        check("t2_ready_e", l_rdy[e], 0);
        check("t2_act", {l_cmd[e+1], l_ba[e+1], l_addr[e+1]}, {ACT, 3'd2, 14'h1234});
        check("t2_wr", {l_cmd[e+6], l_ba[e+6], l_addr[e+6]}, {WR, 3'd2, 14'h0010});
        check("t2_pre", {l_cmd[e+21], l_ba[e+21], l_addr[e+21]}, {PRE, 3'd2, 14'h0000});
        check("t2_nop_count", count(0, e, e+30, NOP), 28);
        check("t2_oe_count", count(1, e, e+30, NOP), 4);
        check("t2_odt_count", count(2, e, e+30, NOP), 4);
        check("t2_oe_odt_11_14", {l_oe[e+11], l_odt[e+11], l_oe[e+14], l_odt[e+14]}, 4'hF);
        check("t2_dq_11", l_dq[e+11], 16'h0201);
        check("t2_dq_12", l_dq[e+12], 16'h0403);
        check("t2_dq_13", l_dq[e+13], 16'h0605);
        check("t2_dq_14", l_dq[e+14], 16'h0807);
        check("t2_ready_26", l_rdy[e+26], 0);
        check("t2_ready_27", l_rdy[e+27], 1);

        // T3: read, T_RAS-bound precharge
        wait_until(239);
        issue(1'b0, 3'd5, 14'd7, 10'h3F8, 64'h0);
        rd_base  = 240;
        rd_beats = 64'hA7A6A5A4A3A2A1A0;
        wait_until(266);
        e = 240;
        check("t3_accept", acc_cyc, e);
        check("t3_act", {l_cmd[e+1], l_ba[e+1], l_addr[e+1]}, {ACT, 3'd5, 14'd7});
        check("t3_rd", {l_cmd[e+6], l_ba[e+6], l_addr[e+6]}, {RD, 3'd5, 14'h03F8});
        check("t3_rdv_count", count(3, e, e+25, NOP), 1);
        check("t3_rdv_15", l_rdv[e+15], 1);
        check("t3_rd_data", l_rdd[e+15], 64'hA7A6A5A4A3A2A1A0);
        check("t3_pre", {l_cmd[e+16], l_ba[e+16]}, {PRE, 3'd5});
        check("t3_oe_none", count(1, e, e+25, NOP), 0);
        check("t3_ready_21", l_rdy[e+21], 0);
        check("t3_ready_22", l_rdy[e+22], 1);
        rd_base = -1000;

        // T4: idle refresh, request held off through T_RFC
        wait_until(983);
        issue(1'b0, 3'd1, 14'h2AA, 10'h055, 64'h0);
        wait_until(1060);
        check("t4_no_early_cmd", count(0, 975, 981, NOP), 7);
        check("t4_ready_980", l_rdy[980], 1);
        check("t4_ready_981", l_rdy[981], 0);
        check("t4_ref", {l_cmd[982], l_ba[982], l_addr[982]}, {REF, 3'd0, 14'd0});
        check("t4_ready_low_trfc", count(4, 981, 1026, NOP), 0);
        check("t4_ready_1027", l_rdy[1027], 1);
        check("t4_no_act_trfc", count(0, 983, 1028, ACT), 0);
        check("t4_accept", acc_cyc, 1028);
        check("t4_act", {l_cmd[1029], l_ba[1029], l_addr[1029]}, {ACT, 3'd1, 14'h2AA});

        // T5: refresh expiry (edge 1761) during a write; queued read waits for REF + T_RFC
        wait_until(1749);
        issue(1'b1, 3'd3, 14'h0ABC, 10'h155, 64'h1122334455667788);
        tick();
        check("t5_wr_accept", acc_cyc, 1750);
        wait_until(1759);
        issue(1'b0, 3'd6, 14'h3FFF, 10'h3FF, 64'h0);
        rd_base  = 1824;
        rd_beats = 64'hDEADBEEFCAFEF00D;
        wait_until(1860);
        e = 1750;
        check("t5_wr", {l_cmd[e+6], l_ba[e+6], l_addr[e+6]}, {WR, 3'd3, 14'h0155});
        check("t5_dq_11", l_dq[e+11], 16'h7788);
        check("t5_dq_12", l_dq[e+12], 16'h5566);
        check("t5_dq_13", l_dq[e+13], 16'h3344);
        check("t5_dq_14", l_dq[e+14], 16'h1122);
        check("t5_oe_count", count(1, e, e+26, NOP), 4);
        check("t5_pre", {l_cmd[e+21], l_ba[e+21]}, {PRE, 3'd3});
        check("t5_no_early_ref", count(0, e, e+27, REF), 0);
        check("t5_ready_27", l_rdy[e+27], 0);
        check("t5_ref", l_cmd[1778], REF);
        check("t5_ready_1822", l_rdy[1822], 0);
        check("t5_ready_1823", l_rdy[1823], 1);
        check("t5_no_act_held", count(0, e+2, 1824, ACT), 0);
        check("t5_rd_accept", acc_cyc, 1824);
        check("t5_act", {l_cmd[1825], l_ba[1825], l_addr[1825]}, {ACT, 3'd6, 14'h3FFF});
        check("t5_rd", {l_cmd[1830], l_addr[1830]}, {RD, 14'h03FF});
        check("t5_rd_data", {l_rdv[1839], l_rdd[1839]}, {1'b1, 64'hDEADBEEFCAFEF00D});

        // T6: reset in the read data phase
        wait_until(1899);
        issue(1'b0, 3'd4, 14'h0100, 10'h020, 64'h0);
        rd_base  = 1900;
        rd_beats = 64'h0F0E0D0C0B0A0908;
        wait_until(1912);
        #2 reset = 1'b1;
        #1;
        check("t6_ddr_rst_n", ddr_rst_n, 0);
        check("t6_cmd_ba_addr", {ras_n, cas_n, we_n, ba, addr}, {NOP, 3'd0, 14'd0});
        check("t6_dq", {dq_oe, odt, dq_out}, 18'd0);
        check("t6_ready_rdv", {req_ready, rd_valid}, 2'b00);
        check("t6_rd_data", rd_data, 64'h0);
        repeat (4) tick();
        check("t6_no_rdv_in_reset", count(3, 1912, 1916, NOP), 0);
        @(negedge clk);
        reset   = 1'b0;
        rd_base = -1000;
        cyc     = 0;
        log_now();
        wait_until(205);
        check("t6_rstn_200", l_rstn[200], 0);
        check("t6_rstn_ready_201", {l_rstn[201], l_rdy[201]}, 2'b11);
        check("t6_no_rdv_after", count(3, 0, 205, NOP), 0);
        check("t6_nop_after", count(0, 0, 205, NOP), 206);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
